reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entry count; power of two, at least 2*INS_COUNT.
REQ-002 SHALL have parameter INS_COUNT, default 4, maximum reservations per cycle.
REQ-003 SHALL have parameter WR_COUNT, default 4, write-back ports.
REQ-004 SHALL have parameter RET_COUNT, default 4, retire lanes.
REQ-005 SHALL have parameter AS_COUNT, default 4, associative lookup ports.
REQ-006 SHALL have parameter DATA_W, default 32, result width.
REQ-007 SHALL have clock  in  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have reset_n  in  1  reset, synchronous, active-low.
REQ-009 SHALL have rsv_valid  in  1  reserve request.
REQ-010 SHALL have rsv_count  in  clog2(INS_COUNT)+1  entries requested, 1..INS_COUNT.
REQ-011 SHALL have rsv_dest / rsv_dest_valid  in  5*INS_COUNT / INS_COUNT  per-lane destination register.
REQ-012 SHALL have rsv_ready / rsv_slots  out  1 / DEPTHLOG2*INS_COUNT  space available; slot of lane i is ins_ptr+i.
REQ-013 SHALL have wr_valid, wr_slot, wr_data, wr_exc  in  WR_COUNT, DEPTHLOG2*WR_COUNT, DATA_W*WR_COUNT, WR_COUNT  result write-back.
REQ-014 SHALL have as_idx, as_reg  in  DEPTHLOG2*AS_COUNT, 5*AS_COUNT  query slot and source register.
REQ-015 SHALL have as_present, as_valid, as_slot, as_val  out  AS_COUNT, AS_COUNT, DEPTHLOG2*AS_COUNT, DATA_W*AS_COUNT  lookup result.
REQ-016 SHALL have ret_valid, ret_dest, ret_dest_valid, ret_data  out  RET_COUNT, 5*RET_COUNT, RET_COUNT, DATA_W*RET_COUNT  retire lanes.
REQ-017 SHALL have ret_ready  in  1  accept all asserted retire lanes.
REQ-018 SHALL have exc_valid / exc_slot  out  1 / DEPTHLOG2  head entry carries an exception.
REQ-019 SHALL have flush / flush_idx / flush_all  in  1 / DEPTHLOG2 / 1  discard entries younger than flush_idx / all entries.
REQ-020 SHALL have used_count  out  DEPTHLOG2+1  occupied entries.

Function
REQ-021 rsv_ready SHALL equal (used_count+INS_COUNT <= DEPTH) and not flush and not flush_all; a reservation is accepted only when rsv_valid and rsv_ready are both high.
REQ-022 An accepted reservation SHALL allocate rsv_count entries at ins_ptr.., clear their written/exc bits, store dest fields, and advance ins_ptr by rsv_count modulo DEPTH next cycle.
REQ-023 A write to an allocated slot SHALL store data and exc and set written; a write to an unallocated slot SHALL be ignored; two ports writing the same slot in one cycle is illegal.
REQ-024 ret_valid[i] SHALL be high (combinationally) for the longest contiguous prefix from ext_ptr of allocated, written, exc=0 entries, capped at RET_COUNT.
REQ-025 When ret_ready is high, ext_ptr SHALL advance by popcount(ret_valid) and those entries SHALL be deallocated; ret_ready with no ret_valid is a no-op.
REQ-026 exc_valid SHALL be high, exc_slot = ext_ptr, while the head entry is allocated, written, exc=1; that entry SHALL never retire and the block SHALL hold until flush_all.
REQ-027 flush SHALL set ins_ptr to flush_idx+1 and deallocate every entry from flush_idx+1 to old ins_ptr-1; flush_idx SHALL be an allocated slot.
REQ-028 flush_all SHALL deallocate every entry and set ins_ptr to ext_ptr; it has priority over flush.
REQ-029 used_count SHALL equal ins_ptr-ext_ptr (mod 2*DEPTH sense) after every update; simultaneous retire and reserve or flush SHALL be applied together.
REQ-030 Lookup SHALL return, combinationally, the youngest allocated entry in [ext_ptr, as_idx-1] with dest_valid and dest=as_reg; as_reg=0 or as_idx=ext_ptr SHALL yield as_present=0, as_val=0.
REQ-031 as_valid SHALL equal the matching entry's written bit; as_slot its index.
REQ-032 Pointers SHALL wrap modulo DEPTH; full (used_count=DEPTH) and empty (0) SHALL be distinguished by used_count.

Reset
REQ-033 On a rising edge with reset_n low: ins_ptr=ext_ptr=0, used_count=0, all allocated/written/exc bits 0; hence ret_valid=0, exc_valid=0, rsv_ready=1; reset SHALL override any concurrent reserve/write/flush.

Structure
REQ-034 The entry typedef (dest, dest_valid, data, exc) and default parameter constants SHALL live in pipTypes.
REQ-035 One sub-module, rob_lookup (single associative search over entries), SHALL be instantiated AS_COUNT times.

Verification
REQ-036 Reserve 4, write slots 0..3, ret_ready=1 -> ret_valid=4'b1111, ext_ptr=4, used_count=0.
REQ-037 Write slots 0,2 only -> ret_valid=4'b0001; after write slot 1 -> lanes 0..1 retire.
REQ-038 Reserve 8 (slots 0..7, dest r5 at 1 and 3), query as_idx=5, as_reg=5 -> as_present=1, as_slot=3; as_reg=0 -> as_present=0.
REQ-039 Slots 0..9 allocated, flush_idx=4 -> ins_ptr=5, used_count=5; late write to slot 7 ignored.
REQ-040 Slot 0 written with exc=1 -> exc_valid=1, exc_slot=0, no retire; flush_all -> used_count=0, exc_valid=0.
REQ-041 Wrap: DEPTH=32, ext_ptr=ins_ptr=30, reserve 4 -> rsv_slots 30,31,0,1, used_count=4; fill to 32 -> rsv_ready=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types and default sizing constants.
// The entry record is what each ROB slot holds besides its state bits.
package pipTypes;
  localparam int PIP_DEPTH     = 32;
  localparam int PIP_INS_COUNT = 4;
  localparam int PIP_WR_COUNT  = 4;
  localparam int PIP_RET_COUNT = 4;
  localparam int PIP_AS_COUNT  = 4;
  localparam int PIP_DATA_W    = 32;
  localparam int REG_W         = 5;

  typedef struct packed {
    logic [REG_W-1:0]      dest;
    logic                  dest_valid;
    logic [PIP_DATA_W-1:0] data;
    logic                  exc;
  } rob_entry_t;
endpackage

// File: rtl/rob_lookup.sv
// One associative search: youngest allocated producer of i_reg
// among slots [i_ext, i_idx-1].
module rob_lookup
  import pipTypes::*;
#(
  parameter int DEPTH  = PIP_DEPTH,
  parameter int DATA_W = PIP_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  i_alloc,
  input  logic [DEPTH-1:0]  i_written,
  input  logic [REG_W-1:0]  i_dest [DEPTH],
  input  logic [DEPTH-1:0]  i_dv,
  input  logic [DATA_W-1:0] i_data [DEPTH],
  input  logic [AW-1:0]     i_ext,
  input  logic [AW-1:0]     i_idx,
  input  logic [REG_W-1:0]  i_reg,
  output logic              o_present,
  output logic              o_valid,
  output logic [AW-1:0]     o_slot,
  output logic [DATA_W-1:0] o_val
);
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_s;

  assign w_span = i_idx - i_ext;

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    o_present = 1'b0;
    o_slot    = '0;
    w_s       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_s = i_ext + AW'(k);
      if (AW'(k) < w_span && i_alloc[w_s] && i_dv[w_s] &&
          i_dest[w_s] == i_reg && i_reg != '0) begin
        o_present = 1'b1;
        o_slot    = w_s;
      end
    end
  end

  assign o_valid = o_present & i_written[o_slot];
  assign o_val   = o_present ? i_data[o_slot] : '0;
endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane reserve, write-back,
// in-order retire, partial/full flush and operand lookup.
module reorder_buffer
  import pipTypes::*;
#(
  parameter int DEPTH     = PIP_DEPTH,
  parameter int INS_COUNT = PIP_INS_COUNT,
  parameter int WR_COUNT  = PIP_WR_COUNT,
  parameter int RET_COUNT = PIP_RET_COUNT,
  parameter int AS_COUNT  = PIP_AS_COUNT,
  parameter int DATA_W    = PIP_DATA_W,
  localparam int DEPTHLOG2 = $clog2(DEPTH),
  localparam int CW        = $clog2(INS_COUNT) + 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rsv_valid,
  input  logic [CW-1:0]                 rsv_count,
  input  logic [REG_W*INS_COUNT-1:0]    rsv_dest,
  input  logic [INS_COUNT-1:0]          rsv_dest_valid,
  output logic                          rsv_ready,
  output logic [DEPTHLOG2*INS_COUNT-1:0] rsv_slots,
  input  logic [WR_COUNT-1:0]           wr_valid,
  input  logic [DEPTHLOG2*WR_COUNT-1:0] wr_slot,
  input  logic [DATA_W*WR_COUNT-1:0]    wr_data,
  input  logic [WR_COUNT-1:0]           wr_exc,
  input  logic [DEPTHLOG2*AS_COUNT-1:0] as_idx,
  input  logic [REG_W*AS_COUNT-1:0]     as_reg,
  output logic [AS_COUNT-1:0]           as_present,
  output logic [AS_COUNT-1:0]           as_valid,
  output logic [DEPTHLOG2*AS_COUNT-1:0] as_slot,
  output logic [DATA_W*AS_COUNT-1:0]    as_val,
  output logic [RET_COUNT-1:0]          ret_valid,
  output logic [REG_W*RET_COUNT-1:0]    ret_dest,
  output logic [RET_COUNT-1:0]          ret_dest_valid,
  output logic [DATA_W*RET_COUNT-1:0]   ret_data,
  input  logic                          ret_ready,
  output logic                          exc_valid,
  output logic [DEPTHLOG2-1:0]          exc_slot,
  input  logic                          flush,
  input  logic [DEPTHLOG2-1:0]          flush_idx,
  input  logic                          flush_all,
  output logic [DEPTHLOG2:0]            used_count
);
  localparam int AW = DEPTHLOG2;
  localparam int UW = AW + 1;

  logic [AW-1:0]     r_ins, r_ext;
  logic [UW-1:0]     r_used;
  logic [DEPTH-1:0]  r_alloc, r_written;
  rob_entry_t        r_ent [DEPTH];

  logic [AW-1:0]     w_rs;
  logic              w_run;
  logic [UW-1:0]     w_ret_cnt, w_ret_eff;
  logic              w_rsv_fire;
  logic [AW-1:0]     w_fl_base, w_flushed, w_ext_n;
  logic [DEPTH-1:0]  w_clr, w_set, w_wr, w_set_dv, w_wr_exc;
  logic [REG_W-1:0]  w_set_dest [DEPTH];
  logic [DATA_W-1:0] w_wr_data [DEPTH];
  logic [REG_W-1:0]  w_dest [DEPTH];
  logic [DEPTH-1:0]  w_dv;
  logic [DATA_W-1:0] w_data [DEPTH];

  // Retire window stops at the first unwritten or faulting entry.
  always_comb begin
    w_run          = 1'b1;
    w_rs           = '0;
    w_ret_cnt      = '0;
    ret_valid      = '0;
    ret_dest       = '0;
    ret_dest_valid = '0;
    ret_data       = '0;
    for (int i = 0; i < RET_COUNT; i++) begin
      w_rs  = r_ext + AW'(i);
      w_run = w_run & r_alloc[w_rs] & r_written[w_rs] & ~r_ent[w_rs].exc;
      ret_valid[i]                 = w_run;
      ret_dest[REG_W*i +: REG_W]   = r_ent[w_rs].dest;
      ret_dest_valid[i]            = r_ent[w_rs].dest_valid;
      ret_data[DATA_W*i +: DATA_W] = DATA_W'(r_ent[w_rs].data);
      w_ret_cnt = w_ret_cnt + UW'(w_run);
    end
  end

  assign rsv_ready = ({1'b0, r_used} + (UW+1)'(INS_COUNT)) <= (UW+1)'(DEPTH)
                     && !flush && !flush_all;
  assign w_rsv_fire = rsv_valid & rsv_ready;
  assign w_fl_base  = flush_idx + AW'(1);
  assign w_flushed  = r_ins - w_fl_base;
  assign w_ret_eff  = ret_ready ? w_ret_cnt : '0;
  assign w_ext_n    = r_ext + AW'(w_ret_eff);

  always_comb begin
    w_clr    = '0;
    w_set    = '0;
    w_wr     = '0;
    w_set_dv = '0;
    w_wr_exc = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_set_dest[j] = '0;
      w_wr_data[j]  = '0;
      w_clr[j] = flush_all
        | (ret_ready && {1'b0, AW'(AW'(j) - r_ext)} < w_ret_cnt)
        | (flush && AW'(AW'(j) - w_fl_base) < w_flushed);
      for (int i = 0; i < INS_COUNT; i++) begin
        if (w_rsv_fire && CW'(i) < rsv_count &&
            AW'(r_ins + AW'(i)) == AW'(j)) begin
          w_set[j]      = 1'b1;
          w_set_dest[j] = rsv_dest[REG_W*i +: REG_W];
          w_set_dv[j]   = rsv_dest_valid[i];
        end
      end
      for (int p = 0; p < WR_COUNT; p++) begin
        if (wr_valid[p] && wr_slot[AW*p +: AW] == AW'(j)) begin
          w_wr[j]      = 1'b1;
          w_wr_data[j] = wr_data[DATA_W*p +: DATA_W];
          w_wr_exc[j]  = wr_exc[p];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ins     <= '0;
      r_ext     <= '0;
      r_used    <= '0;
      r_alloc   <= '0;
      r_written <= '0;
      for (int j = 0; j < DEPTH; j++) r_ent[j].exc <= 1'b0;
    end else begin
      r_ext <= w_ext_n;
      if (flush_all) begin
        r_ins  <= w_ext_n;
        r_used <= '0;
      end else if (flush) begin
        r_ins  <= w_fl_base;
        r_used <= r_used - UW'(w_flushed) - w_ret_eff;
      end else begin
        r_ins  <= r_ins + (w_rsv_fire ? AW'(rsv_count) : '0);
        r_used <= r_used + (w_rsv_fire ? UW'(rsv_count) : '0) - w_ret_eff;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (w_wr[j] && r_alloc[j]) begin
          r_written[j]  <= 1'b1;
          r_ent[j].data <= PIP_DATA_W'(w_wr_data[j]);
          r_ent[j].exc  <= w_wr_exc[j];
        end
        if (w_set[j]) begin
          r_alloc[j]          <= 1'b1;
          r_written[j]        <= 1'b0;
          r_ent[j].exc        <= 1'b0;
          r_ent[j].dest       <= w_set_dest[j];
          r_ent[j].dest_valid <= w_set_dv[j];
        end
        if (w_clr[j]) begin
          r_alloc[j]   <= 1'b0;
          r_written[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rsv_slots = '0;
    for (int i = 0; i < INS_COUNT; i++)
      rsv_slots[AW*i +: AW] = r_ins + AW'(i);
  end

  assign exc_valid  = r_alloc[r_ext] & r_written[r_ext] & r_ent[r_ext].exc;
  assign exc_slot   = r_ext;
  assign used_count = r_used;

  always_comb begin
    w_dv = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_dest[j] = r_ent[j].dest;
      w_dv[j]   = r_ent[j].dest_valid;
      w_data[j] = DATA_W'(r_ent[j].data);
    end
  end

  for (genvar g = 0; g < AS_COUNT; g++) begin : g_lk
    rob_lookup #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W)
    ) u_lookup (
      .i_alloc  (r_alloc),
      .i_written(r_written),
      .i_dest   (w_dest),
      .i_dv     (w_dv),
      .i_data   (w_data),
      .i_ext    (r_ext),
      .i_idx    (as_idx[AW*g +: AW]),
      .i_reg    (as_reg[REG_W*g +: REG_W]),
      .o_present(as_present[g]),
      .o_valid  (as_valid[g]),
      .o_slot   (as_slot[AW*g +: AW]),
      .o_val    (as_val[DATA_W*g +: DATA_W])
    );
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer at default parameters.
// Hand-computed expectations for reserve/retire/lookup/flush/wrap.
module tb_reorder_buffer;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         rsv_valid;
  logic [2:0]   rsv_count;
  logic [19:0]  rsv_dest;
  logic [3:0]   rsv_dest_valid;
  logic         rsv_ready;
  logic [19:0]  rsv_slots;
  logic [3:0]   wr_valid;
  logic [19:0]  wr_slot;
  logic [127:0] wr_data;
  logic [3:0]   wr_exc;
  logic [19:0]  as_idx;
  logic [19:0]  as_reg;
  logic [3:0]   as_present;
  logic [3:0]   as_valid;
  logic [19:0]  as_slot;
  logic [127:0] as_val;
  logic [3:0]   ret_valid;
  logic [19:0]  ret_dest;
  logic [3:0]   ret_dest_valid;
  logic [127:0] ret_data;
  logic         ret_ready;
  logic         exc_valid;
  logic [4:0]   exc_slot;
  logic         flush;
  logic [4:0]   flush_idx;
  logic         flush_all;
  logic [5:0]   used_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rsv_valid     (rsv_valid),
    .rsv_count     (rsv_count),
    .rsv_dest      (rsv_dest),
    .rsv_dest_valid(rsv_dest_valid),
    .rsv_ready     (rsv_ready),
    .rsv_slots     (rsv_slots),
    .wr_valid      (wr_valid),
    .wr_slot       (wr_slot),
    .wr_data       (wr_data),
    .wr_exc        (wr_exc),
    .as_idx        (as_idx),
    .as_reg        (as_reg),
    .as_present    (as_present),
    .as_valid      (as_valid),
    .as_slot       (as_slot),
    .as_val        (as_val),
    .ret_valid     (ret_valid),
    .ret_dest      (ret_dest),
    .ret_dest_valid(ret_dest_valid),
    .ret_data      (ret_data),
    .ret_ready     (ret_ready),
    .exc_valid     (exc_valid),
    .exc_slot      (exc_slot),
    .flush         (flush),
    .flush_idx     (flush_idx),
    .flush_all     (flush_all),
    .used_count    (used_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rsv_valid      = 1'b0;
    rsv_count      = '0;
    rsv_dest       = '0;
    rsv_dest_valid = '0;
    wr_valid       = '0;
    wr_slot        = '0;
    wr_data        = '0;
    wr_exc         = '0;
    as_idx         = '0;
    as_reg         = '0;
    ret_ready      = 1'b0;
    flush          = 1'b0;
    flush_idx      = '0;
    flush_all      = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] s,
                    input logic [31:0] d, input logic e);
    wr_valid[p]        = 1'b1;
    wr_slot[5*p +: 5]  = s;
    wr_data[32*p +: 32] = d;
    wr_exc[p]          = e;
  endtask

  task automatic reserve(input logic [2:0] n);
    rsv_valid = 1'b1;
    rsv_count = n;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset_n   = 1'b0;
    rsv_valid = 1'b1;
    rsv_count = 3'd4;
    tick();
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    chk("rst_used", used_count, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_rsv_ready", rsv_ready, 1);
    chk("rst_slots", rsv_slots, {5'd3, 5'd2, 5'd1, 5'd0});

    // Basic reserve 4 / write 4 / retire 4
    reserve(3'd4);
    chk("t1_used4", used_count, 4);
    chk("t1_ret_none", ret_valid, 0);
    for (int p = 0; p < 4; p++) wr(p, 5'(p), 32'(100 + p), 1'b0);
    tick();
    idle();
    chk("t1_ret_all", ret_valid, 4'b1111);
    chk("t1_data0", ret_data[31:0], 100);
    chk("t1_data3", ret_data[127:96], 103);
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t1_used0", used_count, 0);
    chk("t1_ext4", rsv_slots[4:0], 4);
    chk("t1_ret_after", ret_valid, 0);

    // Hole in written prefix: slots 4..7
    reserve(3'd4);
    wr(0, 5'd4, 32'h44, 1'b0);
    wr(1, 5'd6, 32'h66, 1'b0);
    tick();
    idle();
    chk("t2_prefix1", ret_valid, 4'b0001);
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t2_used3", used_count, 3);
    wr(0, 5'd5, 32'h55, 1'b0);
    tick();
    idle();
    chk("t2_prefix2", ret_valid, 4'b0011);
    chk("t2_data5", ret_data[31:0], 32'h55);
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t2_used1", used_count, 1);
    wr(0, 5'd7, 32'h77, 1'b0);
    tick();
    ret_ready = 1'b1;
    wr_valid  = '0;
    tick();
    idle();
    chk("t2_used0", used_count, 0);

    // Lookup over slots 8..15
    rsv_dest       = {5'd5, 5'd7, 5'd5, 5'd7};
    rsv_dest_valid = 4'b1111;
    reserve(3'd4);
    rsv_dest       = {5'd5, 5'd5, 5'd5, 5'd5};
    rsv_dest_valid = 4'b1110;
    reserve(3'd4);
    chk("t3_used8", used_count, 8);
    as_idx = {5'd10, 5'd8, 5'd13, 5'd13};
    as_reg = {5'd5, 5'd5, 5'd0, 5'd5};
    #1;
    chk("t3_present", as_present, 4'b1001);
    chk("t3_slot0", as_slot[4:0], 11);
    chk("t3_valid0", as_valid[0], 0);
    chk("t3_val_r0", as_val[63:32], 0);
    chk("t3_slot3", as_slot[19:15], 9);
    wr(0, 5'd11, 32'hAB, 1'b0);
    tick();
    wr_valid = '0;
    #1;
    chk("t3_valid_w", as_valid[0], 1);
    chk("t3_val_w", as_val[31:0], 32'hAB);
    as_idx[4:0] = 5'd15;
    #1;
    chk("t3_youngest", as_slot[4:0], 14);
    idle();
    flush_all = 1'b1;
    tick();
    idle();
    chk("t3_flushall", used_count, 0);

    // Partial flush: slots 8..17, keep through 12
    reserve(3'd4);
    reserve(3'd4);
    reserve(3'd2);
    chk("t4_used10", used_count, 10);
    flush     = 1'b1;
    flush_idx = 5'd12;
    #1;
    chk("t4_rdy_flush", rsv_ready, 0);
    tick();
    idle();
    chk("t4_used5", used_count, 5);
    chk("t4_ins13", rsv_slots[4:0], 13);
    wr(0, 5'd15, 32'hDEAD, 1'b0);
    tick();
    idle();
    chk("t4_late_wr", used_count, 5);
    flush_all = 1'b1;
    tick();
    idle();

    // Exception at head blocks retire until flush_all
    reserve(3'd2);
    wr(0, 5'd8, 32'h1, 1'b1);
    wr(1, 5'd9, 32'h2, 1'b0);
    tick();
    idle();
    chk("t5_exc_valid", exc_valid, 1);
    chk("t5_exc_slot", exc_slot, 8);
    chk("t5_no_ret", ret_valid, 0);
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t5_held", used_count, 2);
    flush_all = 1'b1;
    #1;
    chk("t5_rdy_fa", rsv_ready, 0);
    tick();
    idle();
    chk("t5_used0", used_count, 0);
    chk("t5_exc_clr", exc_valid, 0);

    // Advance pointers to 30 then wrap
    for (int k = 0; k < 5; k++) begin
      reserve(3'd4);
      for (int p = 0; p < 4; p++) wr(p, 5'(8 + 4*k + p), 32'(k), 1'b0);
      tick();
      idle();
      ret_ready = 1'b1;
      tick();
      idle();
    end
    reserve(3'd2);
    wr(0, 5'd28, 32'h0, 1'b0);
    wr(1, 5'd29, 32'h0, 1'b0);
    tick();
    idle();
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t6_base_used", used_count, 0);
    chk("t6_base_ptr", rsv_slots[4:0], 30);
    chk("t6_wrap_slots", rsv_slots, {5'd1, 5'd0, 5'd31, 5'd30});
    reserve(3'd4);
    chk("t6_used4", used_count, 4);
    for (int k = 0; k < 6; k++) reserve(3'd4);
    chk("t6_used28", used_count, 28);
    chk("t6_rdy28", rsv_ready, 1);
    reserve(3'd4);
    chk("t6_used32", used_count, 32);
    chk("t6_full", rsv_ready, 0);
    chk("t6_ins_wrap", rsv_slots[4:0], 30);
    wr(0, 5'd30, 32'hA30, 1'b0);
    wr(1, 5'd31, 32'hA31, 1'b0);
    wr(2, 5'd0, 32'hA00, 1'b0);
    wr(3, 5'd1, 32'hA01, 1'b0);
    tick();
    idle();
    chk("t6_ret_wrap", ret_valid, 4'b1111);
    chk("t6_data_l2", ret_data[95:64], 32'hA00);
    ret_ready = 1'b1;
    tick();
    idle();
    chk("t6_used_after", used_count, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
